// File: rtl/burst_mem_chip.sv
// burst_mem_chip: synchronous word memory with byte-enable writes and
// fixed-latency incrementing burst reads.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; accepted when both are high
//   req_we                1 = single-beat write, 0 = burst read
//   req_addr              start word address
//   req_be                byte write enables (writes only)
//   req_wdata             write data
//   req_blen              burst beats minus one (reads only)
//   rsp_valid/rsp_data    read beat, RD_LATENCY cycles after issue
//   rsp_last              final beat of a burst, qualified by rsp_valid
//   busy                  burst in progress or any read beat in flight
module burst_mem_chip #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned BLEN_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [BLEN_WIDTH-1:0]   req_blen,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_last,
   output logic                    busy
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned BYTES = DATA_WIDTH / 8;

   generate
      if (RD_LATENCY == 0 || RD_LATENCY > 4 || (DATA_WIDTH % 8) != 0) begin : g_param_check
         $error("burst_mem_chip: RD_LATENCY must be 1..4 and DATA_WIDTH a multiple of 8");
      end
   endgenerate

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   burst_addr, burst_addr_nx;
   logic [BLEN_WIDTH-1:0]   burst_rem, burst_rem_nx;
   logic                    issue, issue_last, wr_en;
   logic [ADDR_WIDTH-1:0]   issue_addr;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_word;

   // Stage 0 is the memory read itself; stages 1..RD_LATENCY are registers,
   // so a beat issued at edge t0 reaches the outputs at edge t0+RD_LATENCY.
   logic [RD_LATENCY:0]     pv, pl;
   logic [DATA_WIDTH-1:0]   pd [RD_LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         burst_addr <= '0;
         burst_rem  <= '0;
      end else begin
         state      <= state_nx;
         burst_addr <= burst_addr_nx;
         burst_rem  <= burst_rem_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      burst_addr_nx = burst_addr;
      burst_rem_nx  = burst_rem;
      issue         = 1'b0;
      issue_last    = 1'b0;
      issue_addr    = burst_addr;
      req_ready     = 1'b0;
      wr_en         = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = rst_n;
            if (req_valid && rst_n) begin
               if (req_we) begin
                  wr_en = 1'b1;
               end else begin
                  issue      = 1'b1;
                  issue_addr = req_addr;
                  issue_last = (req_blen == '0);
                  if (req_blen != '0) begin
                     state_nx      = S_BURST;
                     burst_addr_nx = req_addr + 1'b1;
                     burst_rem_nx  = req_blen - 1'b1;
                  end
               end
            end
         end
         S_BURST: begin
            // burst_rem counts beats still to issue after this one; the
            // address wraps naturally at ADDR_WIDTH bits.
            issue         = 1'b1;
            issue_last    = (burst_rem == '0);
            burst_addr_nx = burst_addr + 1'b1;
            burst_rem_nx  = burst_rem - 1'b1;
            if (burst_rem == '0) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Memory array kept free of reset so it maps onto block RAM; a read on the
   // same edge as a write sees the old contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < BYTES; i++) begin
            if (req_be[i]) begin
               mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
      if (issue) begin
         rd_word <= mem[issue_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
         pl <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            pd[i] <= '0;
         end
      end else begin
         pv <= {pv[RD_LATENCY-1:0], issue};
         pl <= {pl[RD_LATENCY-1:0], issue & issue_last};
         // Data registers only move with a valid beat, so the output holds
         // the last beat while idle.
         if (pv[0]) begin
            pd[0] <= rd_word;
         end
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            if (pv[i]) begin
               pd[i] <= pd[i-1];
            end
         end
      end
   end

   assign rsp_valid = pv[RD_LATENCY];
   assign rsp_last  = pl[RD_LATENCY];
   assign rsp_data  = pd[RD_LATENCY-1];
   assign busy      = (state == S_BURST) | (|pv);

endmodule

// File: tb/tb_burst_mem_chip.sv
// tb_burst_mem_chip: three burst_mem_chip instances share one request stream
// (A: 12-bit address, latency 2; B: 4-bit address, latency 1; C: 4-bit
// address, latency 4). A reference model predicts every output cycle by cycle.
module tb_burst_mem_chip;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [11:0] req_addr = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_blen = '0;

   logic [2:0]  rr, rv, rl, bz;
   logic [31:0] rd [3];

   always #5 clk = ~clk;

   burst_mem_chip #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LATENCY(2), .BLEN_WIDTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[0]), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_blen(req_blen),
      .rsp_valid(rv[0]), .rsp_data(rd[0]), .rsp_last(rl[0]), .busy(bz[0]));

   burst_mem_chip #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1), .BLEN_WIDTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[1]), .req_we(req_we),
      .req_addr(req_addr[3:0]), .req_be(req_be), .req_wdata(req_wdata), .req_blen(req_blen),
      .rsp_valid(rv[1]), .rsp_data(rd[1]), .rsp_last(rl[1]), .busy(bz[1]));

   burst_mem_chip #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(4), .BLEN_WIDTH(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[2]), .req_we(req_we),
      .req_addr(req_addr[3:0]), .req_be(req_be), .req_wdata(req_wdata), .req_blen(req_blen),
      .rsp_valid(rv[2]), .rsp_data(rd[2]), .rsp_last(rl[2]), .busy(bz[2]));

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int          lat [3] = '{2, 1, 4};
   int unsigned msk [3] = '{32'hFFF, 32'hF, 32'hF};

   // Model state: memory image, expected beats indexed by delivery cycle.
   logic [31:0] mm [3][4096];
   bit          ev [3][8192];
   bit          el [3][8192];
   logic [31:0] ed [3][8192];
   logic [31:0] last_d [3];
   int          ready_from = 0;
   int          last_issue = -100;

   function automatic bit m_ready();
      return rst_n && (cyc >= ready_from);
   endfunction

   function automatic bit m_busy(int d);
      return rst_n && ((cyc < ready_from) || (cyc <= last_issue + lat[d]));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_accept();
      for (int d = 0; d < 3; d++) begin
         int unsigned a;
         a = int'(req_addr) & msk[d];
         if (req_we) begin
            for (int b = 0; b < 4; b++)
               if (req_be[b]) mm[d][a][8*b +: 8] = req_wdata[8*b +: 8];
         end else begin
            for (int k = 0; k <= int'(req_blen); k++) begin
               int t;
               t = cyc + k + lat[d];
               ev[d][t] = 1'b1;
               el[d][t] = (k == int'(req_blen));
               ed[d][t] = mm[d][(a + k) & msk[d]];
            end
         end
      end
      if (!req_we) begin
         ready_from = cyc + int'(req_blen);
         last_issue = cyc + int'(req_blen);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 3; d++) begin
         string n;
         n = (d == 0) ? "A" : (d == 1) ? "B" : "C";
         if (ev[d][cyc]) last_d[d] = ed[d][cyc];
         chk({"req_ready_", n}, 32'(rr[d]), 32'(m_ready()));
         chk({"rsp_valid_", n}, 32'(rv[d]), 32'(ev[d][cyc]));
         chk({"rsp_data_", n}, rd[d], last_d[d]);
         chk({"rsp_last_", n}, 32'(rl[d]), 32'(ev[d][cyc] && el[d][cyc]));
         chk({"busy_", n}, 32'(bz[d]), 32'(m_busy(d)));
      end
   endtask

   task automatic tick();
      bit acc;
      acc = req_valid && m_ready();
      @(posedge clk);
      cyc++;
      if (acc) model_accept();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic send(bit we, logic [11:0] addr, logic [3:0] be, logic [31:0] data, logic [3:0] blen);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = data;
      req_blen  = blen;
      for (int i = 0; i < 32 && !m_ready(); i++) tick();
      tick();
      req_valid = 1'b0;
   endtask

   task automatic do_reset(int n);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         for (int t = 0; t < 8192; t++) ev[d][t] = 1'b0;
         last_d[d] = '0;
      end
      ready_from = 0;
      last_issue = -100;
      check_all();
      idle(n);
      rst_n = 1'b1;
      #1;
      check_all();
   endtask

   initial begin
      #2;
      do_reset(3);

      // Preload every address the directed and random reads can touch.
      for (int a = 0; a < 80; a++) send(1'b1, 12'(a), 4'hF, $urandom, 4'd0);
      send(1'b1, 12'hFFE, 4'hF, 32'hFE00_00FE, 4'd0);
      send(1'b1, 12'hFFF, 4'hF, 32'hFF00_00FF, 4'd0);

      // Byte enables: 0xAABBCCDD then 0x11223344 on bytes 0 and 2.
      send(1'b1, 12'h010, 4'b1111, 32'hAABB_CCDD, 4'd0);
      send(1'b1, 12'h010, 4'b0101, 32'h1122_3344, 4'd0);
      send(1'b0, 12'h010, 4'h0, 32'h0, 4'd0);
      tick();
      tick();
      chk("be_merge_A", rd[0], 32'hAA22_CC44);
      chk("be_last_A", 32'(rv[0] & rl[0]), 32'd1);
      idle(4);

      // Four-beat burst over 5..8.
      for (int a = 5; a <= 8; a++) send(1'b1, 12'(a), 4'hF, 32'(a), 4'd0);
      send(1'b0, 12'd5, 4'h0, 32'h0, 4'd3);
      idle(8);

      // Wrap-around: A wraps at 0xFFF, B/C at 0xF.
      send(1'b0, 12'hFFE, 4'h0, 32'h0, 4'd3);
      idle(8);
      send(1'b0, 12'h00E, 4'h0, 32'h0, 4'd3);
      idle(8);

      // Back-to-back read, write, read-after-write.
      send(1'b0, 12'd1, 4'h0, 32'h0, 4'd0);
      send(1'b1, 12'd2, 4'hF, 32'hC0FF_EE02, 4'd0);
      send(1'b0, 12'd2, 4'h0, 32'h0, 4'd0);
      idle(6);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         bit we;
         we = 1'($urandom_range(0, 1));
         send(we, 12'($urandom_range(0, 63)), 4'($urandom), $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(8);

      // Reset during an eight-beat burst, after beat 2 reaches dut_a.
      send(1'b0, 12'd20, 4'h0, 32'h0, 4'd7);
      idle(4);
      do_reset(2);
      idle(8);
      send(1'b0, 12'd3, 4'h0, 32'h0, 4'd2);
      idle(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/burst_mem_chip.md
Name: burst_mem_chip

Overview:
Parametrised synchronous memory model for system-level simulation and FPGA inference. It has separate write-data and read-data buses in place of the tri-state bus, and per-byte write enables. Reads have a configurable read latency and can run as incrementing bursts. It sits behind the bus/CPU interface as a memory device that can be dropped in.

Parameters:
ADDR_WIDTH, 12, word-address width; depth DEPTH = 1<<ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits; must be a multiple of 8; BYTES = DATA_WIDTH/8
RD_LATENCY, 2, cycles from read issue to rsp_valid; legal range 1..4
BLEN_WIDTH, 4, burst-length field width; a burst is req_blen+1 beats (1..16 at default)

Ports:
clk  input  1  clock; all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = write (single beat), 0 = read (burst)
req_addr  input  ADDR_WIDTH  start word address
req_be  input  BYTES  byte write enables; ignored for reads
req_wdata  input  DATA_WIDTH  write data
req_blen  input  BLEN_WIDTH  beats minus one; ignored for writes
rsp_valid  output  1  rsp_data holds a read beat
rsp_data  output  DATA_WIDTH  read data
rsp_last  output  1  final beat of a burst; qualified by rsp_valid
busy  output  1  FSM in BURST or any read in flight

Behaviour:
- Reset (rst_n low, asynchronous): FSM enters IDLE; read pipeline valid bits cleared. rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, req_ready=1 once rst_n is high. Memory contents are not reset.
- Accept = req_valid & req_ready at a rising edge. No response backpressure exists.
- FSM states:
  - IDLE: req_ready=1.
  - Accepted write: on that edge, memory[req_addr] byte i <= req_wdata byte i for every i with req_be[i]=1. Other bytes keep their value. FSM stays in IDLE. be=0 is an accepted no-op.
  - Accepted read with req_blen=0: issue beat 0 on that edge; stay in IDLE.
  - Accepted read with req_blen>0: issue beat 0, latch the address and remaining count, go to BURST.
  - BURST: req_ready=0. Issue one beat per cycle at address (start+k) mod DEPTH. After issuing beat req_blen, return to IDLE; req_ready=1 in the following cycle.
- Issue/latency: beat k issued at edge t0+k is presented with rsp_valid=1 from edge t0+k+RD_LATENCY for exactly one cycle. rsp_last=1 only on beat req_blen. When idle, rsp_data holds its last value.
- Back-to-back: a new request may be accepted while earlier beats are still in the pipeline. Responses return strictly in issue order with no gaps inside a burst.
- Ordering:
  - Read issued on the same edge a write commits returns the old data; no write is possible in BURST, so this case arises only across separate requests.
  - Read accepted on the edge after a write returns the new data.
- Wrap-around: burst addresses wrap modulo DEPTH; address DEPTH-1 is followed by 0.
- busy = (state==BURST) | any pipeline stage valid.
- Reset mid-burst: burst aborted; in-flight beats dropped with no rsp_valid after reset; no partial writes.
- Out-of-range RD_LATENCY or non-multiple-of-8 DATA_WIDTH: elaboration error via a generate-time check.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> rsp_valid=0, rsp_data=0, busy=0, req_ready=1.
- Byte-enable write: write addr 0x010 data 0xAABBCCDD be=1111, then data 0x11223344 be=0101, then read blen=0 -> one beat 0xAA22CC44 at acceptance+2 with rsp_last=1.
- Burst read: preload addr 5..8 with 5,6,7,8; read addr 5 blen=3 -> req_ready low for 3 cycles; rsp_valid on 4 consecutive cycles starting at acceptance+RD_LATENCY with data 5,6,7,8; rsp_last only on 8.
- Wrap-around: ADDR_WIDTH=4; read addr 0xE blen=3 -> beats from addresses 0xE, 0xF, 0x0, 0x1.
- Back-to-back and read-after-write: read addr 1 blen=0, write addr 2 on the next edge, read addr 2 on the following edge -> two responses in order, the second showing the new data; repeat with RD_LATENCY=1 and RD_LATENCY=4.
- Reset mid-burst: start blen=7 read, assert rst_n low after beat 2 returns -> rsp_valid drops immediately; no beats after reset release; next read returns correct data.
